// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the lab CPU datapath.
// Steps FETCH -> DECODE -> EXEC -> [MEM] -> [WB] per instruction. It owns
// the PC, issues one-phase enables, and halts on HALT opcodes or when a
// memory access times out.
// Optional feature macro: SEQ_PERF_CNT_EN builds the saturating cycle and
// instruction counters. When it is undefined, CYCLE_CNT and INSTR_CNT are
// tied to 0.
module multicycle_sequencer #(
  parameter int unsigned   PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned   MEM_TIMEOUT = 15,
  parameter int unsigned   CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             CTRL_HALT,
  input  logic             CTRL_MEM_READ,
  input  logic             CTRL_MEM_WRITE,
  input  logic             CTRL_REG_WRITE,
  input  logic             BRANCH_TAKEN,
  input  logic [PC_W-1:0]  BRANCH_TARGET,
  input  logic             MEM_ACK,
  output logic [PC_W-1:0]  INSTR_ADDR,
  output logic             IR_LOAD,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic             REG_WE,
  output logic             HALTED,
  output logic             ERR,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e            state;
  state_e            state_nxt;
  logic              retire_c;
  logic              fault_c;
  logic [WAIT_W-1:0] wait_cnt;
  logic [PC_W-1:0]   pc;

  // Next-state decode; also flags retire and fault conditions
  always_comb begin
    state_nxt = state;
    retire_c  = 1'b0;
    fault_c   = 1'b0;
    case (state)
      S_IDLE:   if (START) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = CTRL_HALT ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (CTRL_MEM_READ || CTRL_MEM_WRITE) begin
          state_nxt = S_MEM;
        end else if (CTRL_REG_WRITE) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_FETCH;
          retire_c  = 1'b1;
        end
      end
      S_MEM: begin
        if (MEM_ACK) begin
          if (CTRL_REG_WRITE) begin
            state_nxt = S_WB;
          end else begin
            state_nxt = S_FETCH;
            retire_c  = 1'b1;
          end
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt = S_HALT;
          fault_c   = 1'b1;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire_c  = 1'b1;
      end
      S_HALT:   state_nxt = S_HALT;
      default: begin
        state_nxt = S_HALT;
        fault_c   = 1'b1;
      end
    endcase
  end

  // State, PC and Moore enables registered from the next state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      wait_cnt <= '0;
      IR_LOAD  <= 1'b0;
      MEM_REQ  <= 1'b0;
      MEM_WE   <= 1'b0;
      REG_WE   <= 1'b0;
      HALTED   <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_nxt;
      IR_LOAD  <= (state_nxt == S_FETCH);
      MEM_REQ  <= (state_nxt == S_MEM);
      MEM_WE   <= (state_nxt == S_MEM) && CTRL_MEM_WRITE;
      REG_WE   <= (state_nxt == S_WB);
      HALTED   <= (state_nxt == S_HALT);
      ERR      <= ERR || fault_c;
      // Counts completed MEM cycles of the current access; restarts at 0 on entry
      wait_cnt <= (state == S_MEM && state_nxt == S_MEM) ? wait_cnt + WAIT_W'(1) : '0;
      if (retire_c) begin
        pc <= BRANCH_TAKEN ? BRANCH_TARGET : pc + PC_W'(1);
      end
    end
  end

  assign STATE      = state;
  assign INSTR_ADDR = pc;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             active_c;

  assign active_c = (state != S_IDLE) && (state != S_HALT);

  // Saturating performance counters, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (active_c && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire_c && (instr_cnt != '1)) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign CYCLE_CNT = cycle_cnt;
  assign INSTR_CNT = instr_cnt;
`else
  assign CYCLE_CNT = '0;
  assign INSTR_CNT = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer.
module tb_multicycle_sequencer;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 16;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET, START, CTRL_HALT, CTRL_MEM_READ, CTRL_MEM_WRITE;
  logic             CTRL_REG_WRITE, BRANCH_TAKEN, MEM_ACK;
  logic [PC_W-1:0]  BRANCH_TARGET;
  logic [PC_W-1:0]  INSTR_ADDR;
  logic             IR_LOAD, MEM_REQ, MEM_WE, REG_WE, HALTED, ERR;
  logic [2:0]       STATE;
  logic [CNT_W-1:0] CYCLE_CNT, INSTR_CNT;

  int n_vec = 0;
  int n_err = 0;

  multicycle_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .CTRL_HALT(CTRL_HALT),
    .CTRL_MEM_READ(CTRL_MEM_READ), .CTRL_MEM_WRITE(CTRL_MEM_WRITE),
    .CTRL_REG_WRITE(CTRL_REG_WRITE), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .MEM_ACK(MEM_ACK), .INSTR_ADDR(INSTR_ADDR),
    .IR_LOAD(IR_LOAD), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .REG_WE(REG_WE),
    .HALTED(HALTED), .ERR(ERR), .STATE(STATE), .CYCLE_CNT(CYCLE_CNT),
    .INSTR_CNT(INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Clear decoder inputs, reset, then start: ends in the first FETCH cycle
  task automatic reset_and_start();
    {START, CTRL_HALT, CTRL_MEM_READ, CTRL_MEM_WRITE} = '0;
    {CTRL_REG_WRITE, BRANCH_TAKEN, MEM_ACK} = '0;
    BRANCH_TARGET = '0;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset();
    {START, CTRL_HALT, CTRL_MEM_READ, CTRL_MEM_WRITE} = '0;
    {CTRL_REG_WRITE, BRANCH_TAKEN, MEM_ACK} = '0;
    BRANCH_TARGET = '0;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    n_vec++; if (STATE !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", STATE); end
    n_vec++; if (INSTR_ADDR !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h exp 00", INSTR_ADDR); end
    n_vec++; if ({IR_LOAD, MEM_REQ, MEM_WE, REG_WE, HALTED, ERR} !== 6'b0) begin
      n_err++; $display("FAIL reset_outputs got %b exp 000000", {IR_LOAD, MEM_REQ, MEM_WE, REG_WE, HALTED, ERR}); end
    n_vec++; if ({CYCLE_CNT, INSTR_CNT} !== '0) begin
      n_err++; $display("FAIL reset_counters got %0d/%0d exp 0/0", CYCLE_CNT, INSTR_CNT); end
    tick();
    n_vec++; if (STATE !== 3'd0) begin n_err++; $display("FAIL idle_hold got %0d exp 0", STATE); end
  endtask

  task automatic test_alu_op();
    reset_and_start();
    n_vec++; if (STATE !== 3'd1 || IR_LOAD !== 1'b1) begin
      n_err++; $display("FAIL alu_fetch got st=%0d ir=%b exp st=1 ir=1", STATE, IR_LOAD); end
    tick();
    n_vec++; if (STATE !== 3'd2 || IR_LOAD !== 1'b0) begin
      n_err++; $display("FAIL alu_decode got st=%0d ir=%b exp st=2 ir=0", STATE, IR_LOAD); end
    tick();
    n_vec++; if (STATE !== 3'd3 || INSTR_ADDR !== 8'h00) begin
      n_err++; $display("FAIL alu_exec got st=%0d pc=%h exp st=3 pc=00", STATE, INSTR_ADDR); end
    tick();
    n_vec++; if (STATE !== 3'd1 || INSTR_ADDR !== 8'h01) begin
      n_err++; $display("FAIL alu_retire got st=%0d pc=%h exp st=1 pc=01", STATE, INSTR_ADDR); end
    n_vec++; if (CYCLE_CNT !== (PERF ? 16'd3 : 16'd0) || INSTR_CNT !== (PERF ? 16'd1 : 16'd0)) begin
      n_err++; $display("FAIL alu_counters got %0d/%0d", CYCLE_CNT, INSTR_CNT); end
  endtask

  task automatic test_reg_write();
    int we_cycles;
    reset_and_start();
    CTRL_REG_WRITE = 1'b1;
    we_cycles = 0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (REG_WE === 1'b1) begin
        we_cycles++;
        n_vec++; if (c !== 4 || STATE !== 3'd5) begin
          n_err++; $display("FAIL rw_we_phase got cyc=%0d st=%0d exp cyc=4 st=5", c, STATE); end
      end
    end
    CTRL_REG_WRITE = 1'b0;
    n_vec++; if (we_cycles !== 1) begin n_err++; $display("FAIL rw_we_count got %0d exp 1", we_cycles); end
    n_vec++; if (STATE !== 3'd1 || INSTR_ADDR !== 8'h01) begin
      n_err++; $display("FAIL rw_retire got st=%0d pc=%h exp st=1 pc=01", STATE, INSTR_ADDR); end
    n_vec++; if (CYCLE_CNT !== (PERF ? 16'd4 : 16'd0) || INSTR_CNT !== (PERF ? 16'd1 : 16'd0)) begin
      n_err++; $display("FAIL rw_counters got %0d/%0d", CYCLE_CNT, INSTR_CNT); end
  endtask

  task automatic test_mem_read_wb();
    int req_cycles, we_seen, rwe_cycles, first_fetch;
    reset_and_start();
    CTRL_MEM_READ  = 1'b1;
    CTRL_REG_WRITE = 1'b1;
    req_cycles = 0; we_seen = 0; rwe_cycles = 0; first_fetch = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      MEM_ACK = 1'b0;
      if (MEM_REQ === 1'b1) req_cycles++;
      if (MEM_WE === 1'b1) we_seen++;
      if (REG_WE === 1'b1) rwe_cycles++;
      if (STATE === 3'd1 && first_fetch == 0) first_fetch = c;
      if (c == 6) MEM_ACK = 1'b1;
    end
    {CTRL_MEM_READ, CTRL_REG_WRITE} = 2'b00;
    n_vec++; if (req_cycles !== 3) begin n_err++; $display("FAIL mrd_req_cycles got %0d exp 3", req_cycles); end
    n_vec++; if (we_seen !== 0) begin n_err++; $display("FAIL mrd_mem_we got %0d exp 0", we_seen); end
    n_vec++; if (rwe_cycles !== 1) begin n_err++; $display("FAIL mrd_reg_we got %0d exp 1", rwe_cycles); end
    n_vec++; if (first_fetch !== 8 || INSTR_ADDR !== 8'h01) begin
      n_err++; $display("FAIL mrd_next_fetch got cyc=%0d pc=%h exp cyc=8 pc=01", first_fetch, INSTR_ADDR); end
  endtask

  task automatic test_mem_write();
    reset_and_start();
    CTRL_MEM_READ  = 1'b1;
    CTRL_MEM_WRITE = 1'b1;
    tick();
    tick();
    tick();
    n_vec++; if (STATE !== 3'd4 || MEM_REQ !== 1'b1 || MEM_WE !== 1'b1) begin
      n_err++; $display("FAIL mwr_phase got st=%0d req=%b we=%b exp st=4 req=1 we=1", STATE, MEM_REQ, MEM_WE); end
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    {CTRL_MEM_READ, CTRL_MEM_WRITE} = 2'b00;
    n_vec++; if (STATE !== 3'd1 || MEM_REQ !== 1'b0 || REG_WE !== 1'b0 || INSTR_ADDR !== 8'h01) begin
      n_err++; $display("FAIL mwr_retire got st=%0d req=%b rwe=%b pc=%h exp st=1 req=0 rwe=0 pc=01",
                        STATE, MEM_REQ, REG_WE, INSTR_ADDR); end
  endtask

  task automatic test_branch();
    reset_and_start();
    for (int i = 0; i < 16; i++) begin
      tick(); tick(); tick();
    end
    n_vec++; if (INSTR_ADDR !== 8'h10) begin n_err++; $display("FAIL br_walk got %h exp 10", INSTR_ADDR); end
    n_vec++; if (CYCLE_CNT !== (PERF ? 16'd48 : 16'd0) || INSTR_CNT !== (PERF ? 16'd16 : 16'd0)) begin
      n_err++; $display("FAIL br_counters got %0d/%0d", CYCLE_CNT, INSTR_CNT); end
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 8'h05;
    tick(); tick(); tick();
    n_vec++; if (INSTR_ADDR !== 8'h05 || STATE !== 3'd1) begin
      n_err++; $display("FAIL br_taken got pc=%h st=%0d exp pc=05 st=1", INSTR_ADDR, STATE); end
    BRANCH_TARGET = 8'hFF;
    tick(); tick(); tick();
    n_vec++; if (INSTR_ADDR !== 8'hFF) begin n_err++; $display("FAIL br_to_ff got %h exp ff", INSTR_ADDR); end
    BRANCH_TAKEN = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (INSTR_ADDR !== 8'h00) begin n_err++; $display("FAIL pc_wrap got %h exp 00", INSTR_ADDR); end
    // Branch asserted only before the retire cycle must be ignored
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 8'h33;
    tick(); tick();
    BRANCH_TAKEN = 1'b0;
    tick();
    n_vec++; if (INSTR_ADDR !== 8'h01) begin n_err++; $display("FAIL br_sample_retire got %h exp 01", INSTR_ADDR); end
  endtask

  task automatic test_halt();
    reset_and_start();
    tick(); tick(); tick();
    CTRL_HALT = 1'b1;
    tick(); tick();
    n_vec++; if (STATE !== 3'd6 || HALTED !== 1'b1 || ERR !== 1'b0 || INSTR_ADDR !== 8'h01) begin
      n_err++; $display("FAIL halt_enter got st=%0d h=%b e=%b pc=%h exp st=6 h=1 e=0 pc=01",
                        STATE, HALTED, ERR, INSTR_ADDR); end
    CTRL_HALT = 1'b0;
    START = 1'b1;
    tick(); tick(); tick();
    START = 1'b0;
    n_vec++; if (STATE !== 3'd6 || HALTED !== 1'b1 || INSTR_ADDR !== 8'h01) begin
      n_err++; $display("FAIL halt_sticky got st=%0d h=%b pc=%h exp st=6 h=1 pc=01", STATE, HALTED, INSTR_ADDR); end
    n_vec++; if (CYCLE_CNT !== (PERF ? 16'd5 : 16'd0) || INSTR_CNT !== (PERF ? 16'd1 : 16'd0)) begin
      n_err++; $display("FAIL halt_counters got %0d/%0d", CYCLE_CNT, INSTR_CNT); end
  endtask

  task automatic test_timeout();
    int mem_cycles;
    reset_and_start();
    CTRL_MEM_READ = 1'b1;
    tick(); tick(); tick();
    mem_cycles = 0;
    for (int i = 0; i < 20 && STATE === 3'd4; i++) begin
      mem_cycles++;
      tick();
    end
    CTRL_MEM_READ = 1'b0;
    n_vec++; if (mem_cycles !== 15) begin n_err++; $display("FAIL to_mem_cycles got %0d exp 15", mem_cycles); end
    n_vec++; if (STATE !== 3'd6 || ERR !== 1'b1 || HALTED !== 1'b1 || MEM_REQ !== 1'b0) begin
      n_err++; $display("FAIL to_halt got st=%0d e=%b h=%b req=%b exp st=6 e=1 h=1 req=0",
                        STATE, ERR, HALTED, MEM_REQ); end
    tick(); tick();
    n_vec++; if (ERR !== 1'b1 || STATE !== 3'd6) begin
      n_err++; $display("FAIL to_err_hold got e=%b st=%0d exp e=1 st=6", ERR, STATE); end
    n_vec++; if (CYCLE_CNT !== (PERF ? 16'd18 : 16'd0) || INSTR_CNT !== 16'd0) begin
      n_err++; $display("FAIL to_counters got %0d/%0d", CYCLE_CNT, INSTR_CNT); end
  endtask

  task automatic test_reset_mid_mem();
    reset_and_start();
    tick(); tick(); tick();
    CTRL_MEM_WRITE = 1'b1;
    tick(); tick(); tick(); tick();
    n_vec++; if (STATE !== 3'd4 || MEM_REQ !== 1'b1 || INSTR_ADDR !== 8'h01) begin
      n_err++; $display("FAIL rmm_setup got st=%0d req=%b pc=%h exp st=4 req=1 pc=01", STATE, MEM_REQ, INSTR_ADDR); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    CTRL_MEM_WRITE = 1'b0;
    n_vec++; if (STATE !== 3'd0 || MEM_REQ !== 1'b0 || MEM_WE !== 1'b0 || INSTR_ADDR !== 8'h00) begin
      n_err++; $display("FAIL rmm_reset got st=%0d req=%b we=%b pc=%h exp st=0 req=0 we=0 pc=00",
                        STATE, MEM_REQ, MEM_WE, INSTR_ADDR); end
    n_vec++; if ({CYCLE_CNT, INSTR_CNT} !== '0 || ERR !== 1'b0) begin
      n_err++; $display("FAIL rmm_counters got %0d/%0d err=%b exp 0/0 err=0", CYCLE_CNT, INSTR_CNT, ERR); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_reg_write();
    test_mem_read_wb();
    test_mem_write();
    test_branch();
    test_halt();
    test_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
